cnt_sweep_ctrl: RTL and testbench

CNT_SWEEP_CTRL -- requirements
Module: cnt_sweep_ctrl

---
 rtl/cnt_sweep_ctrl.sv | 112 +++++++++++
 tb/tb_cnt_sweep_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_sweep_ctrl.sv
// Sweep controller for an external up/down counter: it ramps the counter from 0
// to up_lim, then back down to dn_lim, and repeats for `loops` passes (0 = until stop).
module cnt_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] up_lim,
  input  logic [WIDTH-1:0] dn_lim,
  input  logic [2:0]       loops,
  input  logic [WIDTH-1:0] count,
  output logic             mode,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       pass_cnt
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] up_q, up_d, dn_q, dn_d;
  logic [2:0]       loops_q, loops_d, pass_q, pass_d;
  logic             err_q, err_d;
  logic [2:0]       pass_inc;

  assign pass_inc = pass_q + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      up_q    <= '0;
      dn_q    <= '0;
      loops_q <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Outside UP/DOWN the counter is held at 0 and pointed upward, so a sweep
  // always begins from 0.
  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    dn_d    = dn_q;
    loops_d = loops_q;
    pass_d  = pass_q;
    err_d   = 1'b0;
    mode    = 1'b1;
    cnt_rst = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (up_lim > dn_lim) begin
            up_d    = up_lim;
            dn_d    = dn_lim;
            loops_d = loops;
            pass_d  = '0;
            state_d = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        cnt_rst = 1'b0;
        mode    = (count != up_q);
        if (stop) begin
          cnt_rst = 1'b1;
          state_d = IDLE;
        end else if (count == up_q) begin
          state_d = DOWN;
        end
      end
      DOWN: begin
        cnt_rst = 1'b0;
        mode    = (count == dn_q);
        if (stop) begin
          cnt_rst = 1'b1;
          state_d = IDLE;
        end else if (count == dn_q) begin
          pass_d = pass_inc;
          // Last pass clears the counter here rather than turning it upward.
          if (loops_q != 3'd0 && pass_inc == loops_q) begin
            cnt_rst = 1'b1;
            state_d = DONE;
          end else begin
            state_d = UP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == UP) || (state_q == DOWN);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign pass_cnt = pass_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: models the external counter, predicts each job's count
// trace and end event from the sweep rules, and checks them from a negedge monitor.
module tb_cnt_sweep_ctrl;
  localparam int W = 4;
  localparam int EV_DONE = 0, EV_ERR = 1, EV_ABORT = 2;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [W-1:0] up_lim = '0, dn_lim = '0, count = '0;
  logic [2:0]   loops = '0;
  logic         mode, cnt_rst, busy, done, err;
  logic [2:0]   pass_cnt;

  int total = 0, bad = 0;

  typedef struct {int kind; int pass;} ev_t;
  int  cq[$];
  ev_t evq[$];
  int  tr_c[$];
  int  tr_t[$];
  bit  prev_busy = 1'b0;

  cnt_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .up_lim(up_lim), .dn_lim(dn_lim), .loops(loops), .count(count),
    .mode(mode), .cnt_rst(cnt_rst), .busy(busy), .done(done), .err(err),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  // The external counter being controlled.
  always @(posedge clk) count <= cnt_rst ? '0 : (mode ? count + 1'b1 : count - 1'b1);

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cnt_rst"}, cnt_rst, 1);
    chk({tag, "_mode"}, mode, 1);
    chk({tag, "_pass"}, pass_cnt, 0);
  endtask

  // Expected counter values seen while busy: first up leg from 0, then down legs
  // to dn (each ending a pass) and up legs from dn+1, truncated to lim entries.
  function automatic void gen(input int u, input int d, input int l, input int lim);
    int p = 0;
    tr_c.delete();
    tr_t.delete();
    for (int v = 0; v <= u; v++) begin tr_c.push_back(v); tr_t.push_back(0); end
    while (tr_c.size() < lim) begin
      for (int v = u - 1; v >= d; v--) begin tr_c.push_back(v); tr_t.push_back(v == d); end
      p++;
      if (l != 0 && p == l) break;
      for (int v = d + 1; v <= u; v++) begin tr_c.push_back(v); tr_t.push_back(0); end
    end
    while (tr_c.size() > lim) begin void'(tr_c.pop_back()); void'(tr_t.pop_back()); end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_busy <= 1'b0;
    end else begin
      if (busy) begin
        if (cq.size() == 0) chk("unexpected_busy", 1, 0);
        else chk("count", count, cq.pop_front());
      end
      if (done) begin
        if (evq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("done_kind", EV_DONE, evq[0].kind);
          chk("done_pass", pass_cnt, evq[0].pass);
          void'(evq.pop_front());
        end
        chk("done_count", count, 0);
      end else if (prev_busy && !busy) begin
        if (evq.size() == 0) chk("unexpected_abort", 1, 0);
        else begin
          chk("abort_kind", EV_ABORT, evq[0].kind);
          chk("abort_pass", pass_cnt, evq[0].pass);
          void'(evq.pop_front());
        end
        chk("abort_count", count, 0);
      end
      if (err) begin
        if (evq.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          chk("err_kind", EV_ERR, evq[0].kind);
          void'(evq.pop_front());
        end
        chk("err_busy", busy, 0);
        chk("err_count", count, 0);
      end
      prev_busy <= busy;
    end
  end

  // act: 0 = run to completion, 1 = stop during busy cycle j, 2 = reset during busy cycle j
  task automatic run_job(input int u, input int d, input int l, input int act, input int j,
                         input bit hold);
    int turns = 0;
    int n;
    int exp_pass;
    bit ok = 1'b0;
    gen(u, d, l, (act == 0) ? 100000 : j);
    n = (act == 2) ? j - 1 : tr_c.size();
    for (int i = 0; i < n; i++) cq.push_back(tr_c[i]);
    for (int i = 0; i < j - 1 && i < tr_t.size(); i++) turns += tr_t[i];
    exp_pass = (act == 0) ? l : (act == 1) ? turns % 8 : 0;
    if (act == 0) evq.push_back('{EV_DONE, l});
    else if (act == 1) evq.push_back('{EV_ABORT, exp_pass});

    @(posedge clk); #1 start = 1'b1; up_lim = W'(u); dn_lim = W'(d); loops = 3'(l);
    @(posedge clk); #1 start = hold;
    if (act == 1) begin
      repeat (j - 1) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
    end else if (act == 2) begin
      repeat (j - 1) @(posedge clk);
      #3 reset = 1'b1;
      #1 chk_rst_outputs("midrst");
      @(posedge clk); #1 chk("midrst_count", count, 0);
      reset = 1'b0;
    end
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) start = 1'b0;
      if (!busy && !done) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    if (!ok) chk("job_timeout", 1, 0);
    chk("pass_end", pass_cnt, exp_pass);
    // stop in IDLE must be ignored and pass_cnt must hold
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("idle_pass_hold", pass_cnt, exp_pass);
    chk("idle_busy", busy, 0);
  endtask

  task automatic reject(input int u, input int d);
    evq.push_back('{EV_ERR, 0});
    @(posedge clk); #1 start = 1'b1; up_lim = W'(u); dn_lim = W'(d);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rej_busy", busy, 0);
    chk("rej_err_once", err, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int u, d, l;
    @(posedge clk); #1 chk_rst_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    run_job(3, 1, 1, 0, 0, 1'b0);
    run_job(15, 0, 2, 0, 0, 1'b0);
    reject(4, 4);
    run_job(5, 2, 0, 1, 5, 1'b0);
    run_job(5, 1, 1, 2, 9, 1'b0);
    run_job(3, 1, 1, 0, 0, 1'b1);
    run_job(1, 0, 0, 1, 60, 1'b0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        u = $urandom_range(0, 15);
        d = $urandom_range(u, 15);
        reject(u, d);
      end else begin
        u = $urandom_range(1, 15);
        d = $urandom_range(0, u - 1);
        l = $urandom_range(0, 7);
        if (l == 0) run_job(u, d, 0, 1, $urandom_range(1, 60), 1'b0);
        else run_job(u, d, l, 0, 0, 1'($urandom_range(0, 1)));
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", cq.size() + evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
